axi4_burst_slave_mem: RTL
=========================

Name: axi4_burst_slave_mem

Overview:
AXI4 (full) burst slave memory that answers the simple_mips master port (instruction/data fetch bursts and result write-back bursts).
- Used in simulation benches in place of hand-driven M_* stimulus.
- Also usable as an on-chip scratch memory.
- Independent read and write engines share one dual-port word array.
- Supports INCR and FIXED bursts of up to 256 beats, with WSTRB byte enables and per-beat error responses.

Parameters:
C_ADDR_WIDTH, 32, AXI address width.
C_DATA_WIDTH, 32, data width; only 32 is supported.
C_MEM_DEPTH_LOG2, 10, log2 of memory depth in 32-bit words.
C_BASE_ADDR, 32'h12340000, byte address of word 0.
C_RD_LATENCY, 2, idle cycles between AR handshake and the first RVALID; 0 is legal.

Ports:
S_ACLK  in  1  clock
S_ARESET  in  1  synchronous, active-high reset
S_AWVALID/S_AWREADY  in/out  1/1  write address handshake
S_AWADDR  in  C_ADDR_WIDTH  burst start byte address
S_AWLEN  in  8  beats-1
S_AWSIZE  in  3  must be 3'b010
S_AWBURST  in  2  00 FIXED, 01 INCR; others unsupported
S_AWID  in  1  write ID
S_WVALID/S_WREADY  in/out  1/1  write data handshake
S_WDATA  in  32  write data
S_WSTRB  in  4  byte enables
S_WLAST  in  1  last write beat
S_BVALID/S_BREADY  out/in  1/1  write response handshake
S_BRESP  out  2  write response
S_BID  out  1  echoes S_AWID
S_ARVALID/S_ARREADY  in/out  1/1  read address handshake
S_ARADDR  in  C_ADDR_WIDTH  burst start byte address
S_ARLEN  in  8  beats-1
S_ARSIZE  in  3  must be 3'b010
S_ARBURST  in  2  as AWBURST
S_ARID  in  1  read ID
S_RVALID/S_RREADY  out/in  1/1  read data handshake
S_RDATA  out  32  read data
S_RRESP  out  2  per-beat response
S_RLAST  out  1  last read beat
S_RID  out  1  echoes S_ARID

Behaviour:
- Reset: synchronous, takes effect on the first S_ACLK edge with S_ARESET=1.
  - All outputs go to 0 and both FSMs go to IDLE.
  - Memory contents are retained.
  - S_AWREADY and S_ARREADY rise on the first edge after S_ARESET falls.
  - Reset mid-burst abandons the burst; no B or R response is issued for it.
- Address mapping: idx = (addr - C_BASE_ADDR) >> 2.
  - A beat is out of range if addr < C_BASE_ADDR or idx >= 2^C_MEM_DEPTH_LOG2.
  - INCR: addr += 4 per beat, with no 4 KB-boundary check.
  - FIXED: addr is held for the whole burst.
- Burst error: set when SIZE != 3'b010 or BURST is not 00/01.
  - On a burst error every beat is handled as out of range.
  - The beat count is still LEN+1.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1. On the AW handshake, latch addr, len, burst and id, clear the error flag, then go to W_DATA with AWREADY=0.
  - W_DATA: WREADY=1. Each W handshake writes the bytes enabled by WSTRB if the beat is in range; otherwise it writes nothing and sets the error flag.
  - W_DATA, WLAST check: the error flag is set if WLAST differs from (beat==len).
  - W_DATA exit: after exactly LEN+1 beats, drop WREADY and go to W_RESP.
  - W_RESP: BVALID=1, BRESP=error?2'b10:2'b00, BID=latched id. BVALID holds until BREADY, then return to W_IDLE.
  - The minimum write turnaround is therefore one cycle after the B handshake.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: ARREADY=1. On the AR handshake, latch addr, len, burst and id. Go to R_WAIT, or directly to R_DATA when C_RD_LATENCY=0.
  - R_WAIT: counts C_RD_LATENCY cycles.
  - R_DATA, registers: RDATA, RRESP and RLAST are registers, loaded on entry and on each R handshake that is not the last.
  - R_DATA, in range: RDATA=mem[idx], RRESP=00.
  - R_DATA, out of range: RDATA=0, RRESP=10.
  - R_DATA, RLAST: 1 only on beat len.
  - R_DATA, stall: RVALID, RDATA, RRESP, RLAST and RID are held stable while RVALID & !RREADY.
  - R_DATA exit: on the handshake with RLAST=1, go to R_IDLE with RVALID=0.
  - Back-to-back beats at full rate when RREADY stays high.
- Concurrency and ordering:
  - The read and write engines run concurrently.
  - A read-register load in the same cycle as a write to the same word returns the old value.
  - One outstanding burst per direction; no reordering.

Decomposition:
- Package axi4_pkg holds:
  - BURST_FIXED, BURST_INCR, BURST_WRAP
  - RESP_OKAY, RESP_SLVERR
  - SIZE_4B
  - write and read FSM state encodings
- Sub-module axi4_slave_mem_array:
  - 2^C_MEM_DEPTH_LOG2 x 32 words.
  - One synchronous write port with 4-bit byte enable.
  - One asynchronous read port.
- Top level holds both FSMs, the beat counters and the address generators.

Test Plan:
1. Write INCR LEN=3 at 0x12340000, data 1,2,3,4, WSTRB=F, then read back with LEN=3 -> BRESP=00 and BID matches; read returns 1,2,3,4 with RLAST only on beat 4 and RRESP=00.
2. Read INCR LEN=63 with RREADY toggling every other cycle and C_RD_LATENCY=2 -> first RVALID exactly 3 cycles after the AR handshake; 64 beats in order; data stable during stalls.
3. Write 0x11223344 with WSTRB=F, then 0xAABBCCDD with WSTRB=4'b0011, then read -> 0x1122CCDD.
4. Write LEN=3 with WLAST on beat 2 -> all 4 beats accepted, BRESP=2'b10; separately, BREADY held low 5 cycles -> BVALID held and AWREADY=0 until the B handshake.
5. Read LEN=1 at C_BASE_ADDR+4*2^C_MEM_DEPTH_LOG2-4 -> beat0 RRESP=00, beat1 RDATA=0 and RRESP=10. ARBURST=2'b10 LEN=2 -> 3 beats, all SLVERR.
6. S_ARESET pulsed during beat 5 of a 16-beat read -> RVALID=0 at that edge; ARREADY=1 one edge after release; re-read returns the original data.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and FSM state types for the burst slave memory.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;

    // Anything other than a 4-byte FIXED/INCR burst is answered beat-by-beat with SLVERR.
    function automatic logic burst_err(logic [2:0] size, logic [1:0] burst);
        return (size != SIZE_4B) || !((burst == BURST_FIXED) || (burst == BURST_INCR));
    endfunction

endpackage

// File: rtl/axi4_burst_slave_mem_if.sv
// AXI4 slave-side channel bundle (AW, W, B, AR, R) with master/slave views.
interface axi4_burst_slave_mem_if #(
    parameter int unsigned C_ADDR_WIDTH = 32
);
    logic                    awvalid, awready;
    logic [C_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awid;
    logic                    wvalid, wready;
    logic [31:0]             wdata;
    logic [3:0]              wstrb;
    logic                    wlast;
    logic                    bvalid, bready;
    logic [1:0]              bresp;
    logic                    bid;
    logic                    arvalid, arready;
    logic [C_ADDR_WIDTH-1:0] araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arid;
    logic                    rvalid, rready;
    logic [31:0]             rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rid;

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rdata, rresp, rlast, rid
    );

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arlen, arsize, arburst, arid, rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

endinterface

// File: rtl/axi4_slave_mem_array.sv
// Word array with one byte-enabled synchronous write port and one asynchronous read port.
module axi4_slave_mem_array #(
    parameter int unsigned C_MEM_DEPTH_LOG2 = 10
) (
    input  logic                        clk_i,
    input  logic                        we_i,
    input  logic [C_MEM_DEPTH_LOG2-1:0] waddr_i,
    input  logic [31:0]                 wdata_i,
    input  logic [3:0]                  wstrb_i,
    input  logic [C_MEM_DEPTH_LOG2-1:0] raddr_i,
    output logic [31:0]                 rdata_o
);

    logic [31:0] mem_q [2**C_MEM_DEPTH_LOG2];

    // No reset: contents survive S_ARESET.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi4_burst_slave_mem.sv
// AXI4 burst slave memory: independent write and read engines over a shared word array.
module axi4_burst_slave_mem
    import axi4_pkg::*;
#(
    parameter int unsigned             C_ADDR_WIDTH     = 32,
    parameter int unsigned             C_DATA_WIDTH     = 32,
    parameter int unsigned             C_MEM_DEPTH_LOG2 = 10,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR      = 32'h12340000,
    parameter int unsigned             C_RD_LATENCY     = 2
) (
    input  logic                   S_ACLK,
    input  logic                   S_ARESET,
    axi4_burst_slave_mem_if.slave  s
);

    localparam int unsigned IW = C_MEM_DEPTH_LOG2;
    localparam logic [7:0]  LAT_INIT = 8'((C_RD_LATENCY > 0) ? C_RD_LATENCY - 1 : 0);

    typedef logic [C_ADDR_WIDTH-1:0] addr_t;

    if (C_DATA_WIDTH != 32) begin : g_bad_width
        $error("axi4_burst_slave_mem supports only C_DATA_WIDTH == 32");
    end

    function automatic logic in_range(addr_t a);
        return (a >= C_BASE_ADDR) && (((a - C_BASE_ADDR) >> (IW + 2)) == '0);
    endfunction

    function automatic logic [IW-1:0] word_idx(addr_t a);
        return IW'((a - C_BASE_ADDR) >> 2);
    endfunction

    // Holds ready low for the first edge after reset is released.
    logic live_q;

    wr_state_e  w_state_q, w_state_d;
    addr_t      w_addr_q, w_addr_d;
    logic [7:0] w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic       w_fixed_q, w_fixed_d, w_berr_q, w_berr_d, w_err_q, w_err_d, w_id_q, w_id_d;
    logic       w_ok, mem_we;

    rd_state_e  r_state_q, r_state_d;
    addr_t      r_addr_q, r_addr_d, ld_addr;
    logic [7:0] r_len_q, r_len_d, r_beat_q, r_beat_d, r_lat_q, r_lat_d, ld_beat, ld_len;
    logic       r_fixed_q, r_fixed_d, r_berr_q, r_berr_d, r_id_q, r_id_d, ld, ld_berr, ld_ok;
    logic [31:0] rdata_q, rdata_d, mem_rdata;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;

    assign w_ok = in_range(w_addr_q) && !w_berr_q;

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_fixed_d = w_fixed_q;
        w_berr_d  = w_berr_q;
        w_err_d   = w_err_q;
        w_id_d    = w_id_q;
        mem_we    = 1'b0;
        s.awready = 1'b0;
        s.wready  = 1'b0;
        s.bvalid  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                s.awready = live_q;
                if (live_q && s.awvalid) begin
                    w_addr_d  = s.awaddr;
                    w_len_d   = s.awlen;
                    w_beat_d  = '0;
                    w_fixed_d = (s.awburst == BURST_FIXED);
                    w_berr_d  = burst_err(s.awsize, s.awburst);
                    w_err_d   = 1'b0;
                    w_id_d    = s.awid;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                s.wready = 1'b1;
                if (s.wvalid) begin
                    mem_we   = w_ok;
                    if (!w_ok || (s.wlast != (w_beat_q == w_len_q))) w_err_d = 1'b1;
                    w_beat_d = w_beat_q + 8'd1;
                    if (!w_fixed_q) w_addr_d = w_addr_q + addr_t'(4);
                    if (w_beat_q == w_len_q) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                s.bvalid = 1'b1;
                if (s.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign s.bresp = (w_state_q == W_RESP && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s.bid   = w_id_q;

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_fixed_d = r_fixed_q;
        r_berr_d  = r_berr_q;
        r_id_d    = r_id_q;
        r_lat_d   = r_lat_q;
        ld        = 1'b0;
        ld_addr   = r_addr_q;
        ld_beat   = r_beat_q;
        ld_len    = r_len_q;
        ld_berr   = r_berr_q;
        s.arready = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                s.arready = live_q;
                if (live_q && s.arvalid) begin
                    r_addr_d  = s.araddr;
                    r_len_d   = s.arlen;
                    r_beat_d  = '0;
                    r_fixed_d = (s.arburst == BURST_FIXED);
                    r_berr_d  = burst_err(s.arsize, s.arburst);
                    r_id_d    = s.arid;
                    r_lat_d   = LAT_INIT;
                    if (C_RD_LATENCY == 0) begin
                        ld        = 1'b1;
                        ld_addr   = s.araddr;
                        ld_beat   = '0;
                        ld_len    = s.arlen;
                        ld_berr   = r_berr_d;
                        r_state_d = R_DATA;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_lat_q == '0) begin
                    ld        = 1'b1;
                    r_state_d = R_DATA;
                end else begin
                    r_lat_d = r_lat_q - 8'd1;
                end
            end
            R_DATA: begin
                if (s.rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_beat_d = r_beat_q + 8'd1;
                        r_addr_d = r_fixed_q ? r_addr_q : r_addr_q + addr_t'(4);
                        ld       = 1'b1;
                        ld_addr  = r_addr_d;
                        ld_beat  = r_beat_d;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Loads sample the array before this edge's write lands, so a colliding write reads old data.
    assign ld_ok = in_range(ld_addr) && !ld_berr;

    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        rlast_d = rlast_q;
        if (ld) begin
            rdata_d = ld_ok ? mem_rdata : '0;
            rresp_d = ld_ok ? RESP_OKAY : RESP_SLVERR;
            rlast_d = (ld_beat == ld_len);
        end
    end

    assign s.rvalid = (r_state_q == R_DATA);
    assign s.rdata  = rdata_q;
    assign s.rresp  = rresp_q;
    assign s.rlast  = rlast_q;
    assign s.rid    = r_id_q;

    always_ff @(posedge S_ACLK) begin
        if (S_ARESET) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_fixed_q <= 1'b0;
            w_berr_q  <= 1'b0;
            w_err_q   <= 1'b0;
            w_id_q    <= 1'b0;
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_fixed_q <= 1'b0;
            r_berr_q  <= 1'b0;
            r_id_q    <= 1'b0;
            r_lat_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_fixed_q <= w_fixed_d;
            w_berr_q  <= w_berr_d;
            w_err_q   <= w_err_d;
            w_id_q    <= w_id_d;
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_fixed_q <= r_fixed_d;
            r_berr_q  <= r_berr_d;
            r_id_q    <= r_id_d;
            r_lat_q   <= r_lat_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    axi4_slave_mem_array #(
        .C_MEM_DEPTH_LOG2(C_MEM_DEPTH_LOG2)
    ) u_mem (
        .clk_i   (S_ACLK),
        .we_i    (mem_we),
        .waddr_i (word_idx(w_addr_q)),
        .wdata_i (s.wdata),
        .wstrb_i (s.wstrb),
        .raddr_i (word_idx(ld_addr)),
        .rdata_o (mem_rdata)
    );

endmodule
